// File: rtl/dpm_seq_pkg.sv
// Shared types and encodings for the DPM multiply/divide step sequencer.
package dpm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    STEP,
    FIXUP,
    DONE
  } state_e;

  // Shift-select encodings driven onto the ALP array (active low).
  localparam logic [1:0] SHF_NONE = 2'b11;
  localparam logic [1:0] SHF_R    = 2'b01;
  localparam logic [1:0] SHF_L    = 2'b10;

  // ALP opcodes issued by the sequencer.
  localparam logic [9:0] OP_NOP      = 10'h000;
  localparam logic [9:0] OP_ZERO_A   = 10'h001;
  localparam logic [9:0] OP_PASS_SHR = 10'h010;
  localparam logic [9:0] OP_ADD_SHR  = 10'h011;
  localparam logic [9:0] OP_ADD_SHL  = 10'h021;
  localparam logic [9:0] OP_SUB_SHL  = 10'h022;
  localparam logic [9:0] OP_ADD      = 10'h031;
  localparam logic [9:0] OP_SUB      = 10'h032;

  // Operand size code to loop length: byte, word, long (both upper codes).
  function automatic int unsigned size_to_steps(input logic [1:0] d_size);
    case (d_size)
      2'b00:   return 8;
      2'b01:   return 16;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/dpm_muldiv_seq_if.sv
// Sequencer-side bundle: start/size decode in, ALP status in, opcode/shift out.
interface dpm_muldiv_seq_if #(
  parameter int STEP_W = 6
);
  logic              start_h;
  logic              op_div_h;
  logic              signed_h;
  logic [1:0]        d_size_h;
  logic              abort_h;
  logic              q_so0_l;
  logic              alu_n_h;
  logic              mplr_neg_h;
  logic [9:0]        opc_h;
  logic [1:0]        shf_l;
  logic              busy_h;
  logic              done_h;
  logic [STEP_W-1:0] step_h;

  // Microsequencer / array side.
  modport master (
    output start_h, op_div_h, signed_h, d_size_h, abort_h,
           q_so0_l, alu_n_h, mplr_neg_h,
    input  opc_h, shf_l, busy_h, done_h, step_h
  );

  // Sequencer side.
  modport slave (
    input  start_h, op_div_h, signed_h, d_size_h, abort_h,
           q_so0_l, alu_n_h, mplr_neg_h,
    output opc_h, shf_l, busy_h, done_h, step_h
  );
endinterface

// File: rtl/dpm_step_ctr.sv
// Loadable down-counter tracking remaining loop steps; flags the final step.
module dpm_step_ctr #(
  parameter int STEP_W = 6
) (
  input  logic              clk_h,
  input  logic              reset_l,
  input  logic              clr_h,
  input  logic              load_h,
  input  logic              dec_h,
  input  logic [STEP_W-1:0] load_val_h,
  output logic [STEP_W-1:0] count_h,
  output logic              last_h
);

  // Clear beats load beats decrement; the count never wraps below zero.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l)                      count_h <= '0;
    else if (clr_h)                    count_h <= '0;
    else if (load_h)                   count_h <= load_val_h;
    else if (dec_h && count_h != '0)   count_h <= count_h - STEP_W'(1);
  end

  assign last_h = (count_h == STEP_W'(1));

endmodule

// File: rtl/dpm_muldiv_seq.sv
// Multiply/divide step sequencer: drives ALP opcode and shift select through
// an INIT, N-step loop, one-cycle fixup and a done pulse.
module dpm_muldiv_seq
  import dpm_seq_pkg::*;
#(
  parameter int STEP_W = 6
) (
  input  logic            clk_h,
  input  logic            reset_l,
  dpm_muldiv_seq_if.slave bus
);

  state_e            state;
  logic              op_div_q;
  logic              signed_q;
  logic              mplr_neg_q;
  logic              first_q;
  logic              alu_n_q;
  logic [STEP_W-1:0] n_q;
  logic [STEP_W-1:0] step_cnt;
  logic              step_last;
  logic              abort_any;
  logic [9:0]        opc;
  logic [1:0]        shf;

  // Abort only matters once the sequencer owns the array.
  assign abort_any = bus.abort_h && (state != IDLE);

  dpm_step_ctr #(.STEP_W(STEP_W)) u_step_ctr (
    .clk_h      (clk_h),
    .reset_l    (reset_l),
    .clr_h      (abort_any),
    .load_h     (state == INIT),
    .dec_h      (state == STEP),
    .load_val_h (n_q),
    .count_h    (step_cnt),
    .last_h     (step_last)
  );

  // Sequence state, start-time latches and the previous-step ALU sign.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state      <= IDLE;
      op_div_q   <= 1'b0;
      signed_q   <= 1'b0;
      mplr_neg_q <= 1'b0;
      first_q    <= 1'b0;
      alu_n_q    <= 1'b0;
      n_q        <= '0;
    end else if (abort_any) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_h) begin
            op_div_q   <= bus.op_div_h;
            signed_q   <= bus.signed_h;
            mplr_neg_q <= bus.mplr_neg_h;
            n_q        <= STEP_W'(size_to_steps(bus.d_size_h));
            state      <= INIT;
          end
        end
        INIT: begin
          first_q <= 1'b1;
          state   <= STEP;
        end
        STEP: begin
          alu_n_q <= bus.alu_n_h;
          first_q <= 1'b0;
          if (step_last) state <= FIXUP;
        end
        FIXUP:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Opcode/shift decode from state plus the live multiplier LSB.
  // NOTE: defaults first so every path assigns opc/shf and no latch is inferred.
  always_comb begin
    opc = OP_NOP;
    shf = SHF_NONE;
    case (state)
      INIT: opc = OP_ZERO_A;
      STEP: begin
        if (op_div_q) begin
          shf = SHF_L;
          opc = (first_q || !alu_n_q) ? OP_SUB_SHL : OP_ADD_SHL;
        end else begin
          shf = SHF_R;
          opc = bus.q_so0_l ? OP_PASS_SHR : OP_ADD_SHR;
        end
      end
      FIXUP: begin
        if (op_div_q) opc = alu_n_q ? OP_ADD : OP_NOP;
        else          opc = (signed_q && mplr_neg_q) ? OP_SUB : OP_NOP;
      end
      default: ;
    endcase
  end

  assign bus.opc_h  = opc;
  assign bus.shf_l  = shf;
  assign bus.busy_h = (state != IDLE);
  assign bus.done_h = (state == DONE);
  assign bus.step_h = step_cnt;

endmodule
